// File: rtl/adc_moving_average_if.sv
// Sample-in / average-out bus for the ADC boxcar filter.
// master drives samples and clear; slave is the filter.
interface adc_moving_average_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic                    clear;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    ready;
  logic [SAMPLE_WIDTH-1:0] avg_out;
  logic                    avg_valid;
  logic                    full;

  modport master (
    output clear, sample_in, sample_valid,
    input  ready, avg_out, avg_valid, full
  );

  modport slave (
    input  clear, sample_in, sample_valid,
    output ready, avg_out, avg_valid, full
  );
endinterface

// File: rtl/adc_moving_average.sv
// Boxcar moving average over the last 2**LOG2_N ADC samples, using a
// zero-initialised circular buffer, a running sum and a two-stage pipeline.
//
// state | meaning
// INIT  | writing 0 to buffer[init_ptr], one address per cycle; ready=0
// RUN   | accepting samples; stage 1 reads oldest, stage 2 updates sum/buffer
module adc_moving_average #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LOG2_N       = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  adc_moving_average_if.slave bus
);

  localparam int SUM_W = SAMPLE_WIDTH + LOG2_N;
  localparam int N     = 2 ** LOG2_N;

  localparam logic [LOG2_N-1:0] PTR_ONE  = {{(LOG2_N-1){1'b0}}, 1'b1};
  localparam logic [LOG2_N-1:0] PTR_LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N:0]   CNT_ONE  = {{LOG2_N{1'b0}}, 1'b1};
  localparam logic [LOG2_N:0]   CNT_MAX  = {1'b1, {LOG2_N{1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [LOG2_N-1:0]       init_ptr_q, init_ptr_d;
  logic [LOG2_N-1:0]       wptr_q, wptr_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [LOG2_N:0]         cnt_q, cnt_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [SAMPLE_WIDTH-1:0] s1_sample_q, s1_sample_d;
  logic [LOG2_N-1:0]       s1_addr_q, s1_addr_d;
  logic [SAMPLE_WIDTH-1:0] avg_q, avg_d;
  logic                    avg_valid_q, avg_valid_d;
  logic                    full_q, full_d;

  logic [SAMPLE_WIDTH-1:0] mem [N];
  logic [SAMPLE_WIDTH-1:0] rd_data_q;
  logic                    mem_we;
  logic [LOG2_N-1:0]       mem_waddr;
  logic [SAMPLE_WIDTH-1:0] mem_wdata;
  logic                    rd_en;
  logic [SUM_W-1:0]        new_sum;

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    wptr_d      = wptr_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    s1_valid_d  = 1'b0;
    s1_sample_d = s1_sample_q;
    s1_addr_d   = s1_addr_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    full_d      = full_q;
    mem_we      = 1'b0;
    mem_waddr   = init_ptr_q;
    mem_wdata   = '0;
    rd_en       = 1'b0;
    // The oldest sample is always a term of sum_q, so this cannot underflow.
    new_sum     = sum_q + {{LOG2_N{1'b0}}, s1_sample_q} - {{LOG2_N{1'b0}}, rd_data_q};

    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (bus.clear) begin
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + PTR_ONE;
          if (init_ptr_q == PTR_LAST) begin
            state_d = ST_RUN;
            wptr_d  = '0;
            sum_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
          sum_d      = '0;
          cnt_d      = '0;
          avg_d      = '0;
          full_d     = 1'b0;
        end else begin
          if (s1_valid_q) begin
            mem_we      = 1'b1;
            mem_waddr   = s1_addr_q;
            mem_wdata   = s1_sample_q;
            sum_d       = new_sum;
            avg_d       = new_sum[SUM_W-1:LOG2_N];
            avg_valid_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_MAX) full_d = 1'b1;
          end
          if (bus.sample_valid) begin
            rd_en       = 1'b1;
            s1_valid_d  = 1'b1;
            s1_sample_d = bus.sample_in;
            s1_addr_d   = wptr_q;
            wptr_d      = wptr_q + PTR_ONE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      wptr_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_addr_q   <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      wptr_q      <= wptr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_addr_q   <= s1_addr_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      full_q      <= full_d;
    end
  end

  // No reset here so the buffer maps onto block RAM; INIT clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en) rd_data_q <= mem[wptr_q];
  end

  assign bus.ready     = (state_q == ST_RUN);
  assign bus.avg_out   = avg_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.full      = full_q;

endmodule
